// File: rtl/cmd_register_bank.sv
// Executes decoded USB commands against an 8-bit configuration register bank.
// Writes update R/W registers; reads push R/W or read-only status bytes into the PC-read FIFO.
module cmd_register_bank #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_RO    = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [7:0]            header,
    input  logic [7:0]            address,
    input  logic [7:0]            value,
    input  logic                  write,
    input  logic                  read,
    input  logic [3:0]            sorter_state,
    input  logic [NUM_RO*8-1:0]   ro_data,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic [NUM_REGS-1:0]   reg_update,
    output logic [7:0]            fifo_din,
    output logic                  fifo_wr,
    output logic                  addr_err,
    output logic [15:0]           byte_count
);

    localparam int unsigned RW_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned RO_AW = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
    localparam logic [8:0]  RW_N  = 9'(NUM_REGS);
    localparam logic [7:0]  RO_N  = 8'(NUM_RO);
    localparam logic [7:0]  RW_LAST = 8'(NUM_REGS - 1);
    localparam logic [7:0]  RO_LAST = 8'(128 + NUM_RO - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state, state_next;
    logic [7:0] ptr;
    logic [7:0] regs [NUM_REGS];
    logic [7:0] ro_bytes [NUM_RO];

    logic             start, strobe, in_rw, in_ro;
    logic [RW_AW-1:0] rw_idx;
    logic [RO_AW-1:0] ro_idx;
    logic [7:0]       rd_byte, ptr_inc;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end
    for (genvar g = 0; g < NUM_RO; g++) begin : g_ro
        assign ro_bytes[g] = ro_data[8*g +: 8];
    end

    assign start  = (sorter_state == 4'hE);
    assign strobe = write | read;
    assign in_rw  = ({1'b0, ptr} < RW_N);
    assign in_ro  = ptr[7] && ({1'b0, ptr[6:0]} < RO_N);
    assign rw_idx = ptr[RW_AW-1:0];
    assign ro_idx = ptr[RO_AW-1:0];

    always_comb begin
        state_next = state;
        if (start)
            state_next = ACTIVE;
    end

    // Auto-increment wraps inside the region the pointer currently addresses.
    always_comb begin
        rd_byte = 8'hEE;
        ptr_inc = ptr + 8'd1;
        if (in_rw) begin
            rd_byte = regs[rw_idx];
            if (ptr == RW_LAST)
                ptr_inc = '0;
        end else if (in_ro) begin
            rd_byte = ro_bytes[ro_idx];
            if (ptr == RO_LAST)
                ptr_inc = 8'h80;
        end
    end

    always_ff @(posedge clk) begin
        if (res)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= RESET_VAL;
            ptr        <= '0;
            reg_update <= '0;
            fifo_din   <= '0;
            fifo_wr    <= 1'b0;
            addr_err   <= 1'b0;
            byte_count <= '0;
        end else begin
            reg_update <= '0;
            fifo_wr    <= 1'b0;
            if (start) begin
                // A strobe colliding with a start is dropped and flagged.
                ptr <= address;
                if (strobe)
                    addr_err <= 1'b1;
            end else if (strobe) begin
                if (state == IDLE) begin
                    addr_err <= 1'b1;
                end else begin
                    byte_count <= byte_count + 16'd1;
                    if (write) begin
                        if (in_rw) begin
                            regs[rw_idx]       <= value;
                            reg_update[rw_idx] <= 1'b1;
                        end else begin
                            addr_err <= 1'b1;
                        end
                    end
                    if (read) begin
                        fifo_wr  <= 1'b1;
                        fifo_din <= rd_byte;
                        if (!in_rw && !in_ro)
                            addr_err <= 1'b1;
                    end
                    if (header[1])
                        ptr <= ptr_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmd_register_bank.sv
// Directed self-checking bench for cmd_register_bank: inputs change and outputs
// are sampled on the falling clock edge.
module tb_cmd_register_bank;

    logic         clk = 1'b0;
    logic         res;
    logic [7:0]   header, address, value;
    logic         write, read;
    logic [3:0]   sorter_state;
    logic [31:0]  ro_data;
    logic [255:0] regs_flat;
    logic [31:0]  reg_update;
    logic [7:0]   fifo_din;
    logic         fifo_wr, addr_err;
    logic [15:0]  byte_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmd_register_bank #(.NUM_REGS(32), .NUM_RO(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .res(res), .header(header), .address(address), .value(value),
        .write(write), .read(read), .sorter_state(sorter_state), .ro_data(ro_data),
        .regs_flat(regs_flat), .reg_update(reg_update), .fifo_din(fifo_din),
        .fifo_wr(fifo_wr), .addr_err(addr_err), .byte_count(byte_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rb(input int i);
        return regs_flat[8*i +: 8];
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        res = 1'b1; write = 1'b0; read = 1'b0; sorter_state = 4'h0;
        step(); step();
        res = 1'b0;
    endtask

    task automatic start_cmd(input logic [7:0] a, input logic [7:0] h);
        header = h; address = a; sorter_state = 4'hE;
        step();
        sorter_state = 4'h0;
    endtask

    initial begin
        header = '0; address = '0; value = '0; ro_data = 32'hDEADBEEF;
        do_reset();
        chk("rst_regs0", {24'h0, rb(0)}, 32'h00);
        chk("rst_fifo_wr", {31'h0, fifo_wr}, 32'h0);
        chk("rst_fifo_din", {24'h0, fifo_din}, 32'h00);
        chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
        chk("rst_count", {16'h0, byte_count}, 32'h0);
        chk("rst_update", reg_update, 32'h0);

        // Repeated writes without auto-increment hit one register
        start_cmd(8'h05, 8'h01);
        write = 1'b1; value = 8'h11; step();
        value = 8'h22; step();
        write = 1'b0; step();
        chk("t2_reg5", {24'h0, rb(5)}, 32'h22);
        chk("t2_reg6", {24'h0, rb(6)}, 32'h00);
        chk("t2_count", {16'h0, byte_count}, 32'd2);

        do_reset();
        // Auto-increment writes 0x02..0x04
        start_cmd(8'h02, 8'h03);
        write = 1'b1; value = 8'hA1; step();
        chk("t1_upd2", reg_update, 32'h0000_0004);
        chk("t1_reg2", {24'h0, rb(2)}, 32'hA1);
        value = 8'hB2; step();
        chk("t1_upd3", reg_update, 32'h0000_0008);
        chk("t1_reg3", {24'h0, rb(3)}, 32'hB2);
        value = 8'hC3; step();
        chk("t1_upd4", reg_update, 32'h0000_0010);
        chk("t1_reg4", {24'h0, rb(4)}, 32'hC3);
        write = 1'b0; step();
        chk("t1_upd_off", reg_update, 32'h0);
        chk("t1_count", {16'h0, byte_count}, 32'd3);

        // Back-to-back reads with one-cycle latency
        start_cmd(8'h02, 8'h02);
        chk("t3_idle_wr", {31'h0, fifo_wr}, 32'h0);
        read = 1'b1; step();
        chk("t3_wr0", {31'h0, fifo_wr}, 32'h1);
        chk("t3_din0", {24'h0, fifo_din}, 32'hA1);
        step();
        chk("t3_wr1", {31'h0, fifo_wr}, 32'h1);
        chk("t3_din1", {24'h0, fifo_din}, 32'hB2);
        read = 1'b0; step();
        chk("t3_wr2", {31'h0, fifo_wr}, 32'h0);
        start_cmd(8'h04, 8'h02);
        read = 1'b1; step();
        read = 1'b0;
        chk("t3_din2", {24'h0, fifo_din}, 32'hC3);
        step();
        chk("t3_wr_off", {31'h0, fifo_wr}, 32'h0);

        // R/W region wrap: 0x1F -> 0x00 for writes then reads
        start_cmd(8'h1F, 8'h03);
        write = 1'b1; value = 8'h5A; step();
        value = 8'h7C; step();
        write = 1'b0;
        chk("t4_reg31", {24'h0, rb(31)}, 32'h5A);
        chk("t4_reg0", {24'h0, rb(0)}, 32'h7C);
        start_cmd(8'h1F, 8'h02);
        read = 1'b1; step();
        chk("t4_din31", {24'h0, fifo_din}, 32'h5A);
        step();
        read = 1'b0;
        chk("t4_din0", {24'h0, fifo_din}, 32'h7C);
        // Read-only region, including wrap 0x83 -> 0x80
        start_cmd(8'h80, 8'h02);
        read = 1'b1; step();
        chk("t4_ro0", {24'h0, fifo_din}, 32'hEF);
        step();
        read = 1'b0;
        chk("t4_ro1", {24'h0, fifo_din}, 32'hBE);
        start_cmd(8'h83, 8'h02);
        read = 1'b1; step();
        chk("t4_ro3", {24'h0, fifo_din}, 32'hDE);
        step();
        read = 1'b0;
        chk("t4_ro_wrap", {24'h0, fifo_din}, 32'hEF);
        chk("t4_no_err", {31'h0, addr_err}, 32'h0);
        chk("t4_count", {16'h0, byte_count}, 32'd14);

        // Write to read-only space and read from unmapped space
        start_cmd(8'h80, 8'h01);
        write = 1'b1; value = 8'h99; step();
        write = 1'b0;
        chk("t5_werr", {31'h0, addr_err}, 32'h1);
        chk("t5_upd", reg_update, 32'h0);
        chk("t5_reg0", {24'h0, rb(0)}, 32'h7C);
        start_cmd(8'h40, 8'h00);
        read = 1'b1; step();
        read = 1'b0;
        chk("t5_ee_wr", {31'h0, fifo_wr}, 32'h1);
        chk("t5_ee", {24'h0, fifo_din}, 32'hEE);
        step(); step(); step();
        chk("t5_sticky", {31'h0, addr_err}, 32'h1);
        chk("t5_count", {16'h0, byte_count}, 32'd16);

        // Reset in the middle of a 4-byte read
        start_cmd(8'h02, 8'h02);
        read = 1'b1; step();
        chk("t6_din0", {24'h0, fifo_din}, 32'hA1);
        res = 1'b1; step();
        res = 1'b0; read = 1'b0;
        chk("t6_wr", {31'h0, fifo_wr}, 32'h0);
        chk("t6_reg2", {24'h0, rb(2)}, 32'h00);
        chk("t6_count", {16'h0, byte_count}, 32'd0);
        chk("t6_err", {31'h0, addr_err}, 32'h0);
        // Strobe before any start is ignored but flagged
        read = 1'b1; step();
        read = 1'b0;
        chk("t6_idle_wr", {31'h0, fifo_wr}, 32'h0);
        chk("t6_idle_err", {31'h0, addr_err}, 32'h1);
        chk("t6_idle_count", {16'h0, byte_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
